// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose:
//   UART transmitter. It accepts one payload word through a valid/ready
//   handshake and sends it as one asynchronous frame: a start bit, the data
//   bits LSB first, an optional parity bit, and one or two stop bits. Every
//   bit boundary lines up with the external baud_tick strobe. The cycle that
//   accepts the word is never used as a bit boundary.
//
// Parameters:
//   DATA_BITS  payload width, 5..8
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  number of stop bits, 1 or 2
//
// Ports:
//   clk        sole clock; all state changes on its rising edge
//   rst        synchronous, active-high reset; overrides every other input
//   baud_tick  one-clk strobe, one per bit period
//   tx_data    word to send; sampled only when it is accepted
//   tx_valid   tx_data is valid
//   tx_ready   block can accept a word (decoded from registered state)
//   txd        serial line, idle high (registered)
//   tx_busy    frame in progress, always equal to ~tx_ready
//   tx_done    one-clk pulse on the edge that returns the FSM to IDLE
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic        PAR_EN    = (PARITY != 0);
    localparam logic        PAR_ODD   = (PARITY == 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 txd_q, txd_d;
    logic                 done_q, done_d;

    // Next-state and next-output logic. Every registered output is computed
    // here and captured in the state register process. No input reaches an
    // output port without first passing through a flop.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A baud_tick while idle has no effect. Only the handshake
                // moves the FSM out of IDLE.
                txd_d = 1'b1;
                if (tx_valid) begin
                    state_d    = WAIT;
                    shift_d    = tx_data;
                    // Parity is taken from the word at acceptance, because
                    // the shift register is consumed while the bits go out.
                    par_d      = (^tx_data) ^ PAR_ODD;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end

            WAIT: begin
                // The line stays high until the first baud_tick, so the
                // start bit is a full bit period long.
                if (baud_tick) begin
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end

            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = '0;
                end
            end

            DATA: begin
                // bit_cnt_q gives the index of the data bit now on txd.
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PAR_EN) begin
                            state_d = PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d    = STOP;
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end
            end

            PAR: begin
                if (baud_tick) begin
                    state_d    = STOP;
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end

            STOP: begin
                // stop_cnt_q gives the index of the stop period now running.
                if (baud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = ~tx_ready;
    assign txd      = txd_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] vld = 4'b0000;

    logic txd_w  [4];
    logic rdy_w  [4];
    logic busy_w [4];
    logic done_w [4];

    int n_cmp = 0;
    int n_err = 0;
    int bcnt  = 0;

    always #5 clk = ~clk;

    // A one-clk baud strobe every 20 clocks. It changes on the falling edge,
    // so it is stable at each rising edge.
    always @(negedge clk) begin
        if (bcnt == 19) begin
            bcnt = 0;
            baud_tick = 1'b1;
        end else begin
            bcnt = bcnt + 1;
            baud_tick = 1'b0;
        end
    end

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(vld[0]), .tx_ready(rdy_w[0]), .txd(txd_w[0]),
        .tx_busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(vld[1]), .tx_ready(rdy_w[1]), .txd(txd_w[1]),
        .tx_busy(busy_w[1]), .tx_done(done_w[1]));

    uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(vld[2]), .tx_ready(rdy_w[2]), .txd(txd_w[2]),
        .tx_busy(busy_w[2]), .tx_done(done_w[2]));

    uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(vld[3]), .tx_ready(rdy_w[3]), .txd(txd_w[3]),
        .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_all(input string tag);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s_d%0d_txd", tag, d), txd_w[d], 1'b1);
            chk($sformatf("%s_d%0d_rdy", tag, d), rdy_w[d], 1'b1);
            chk($sformatf("%s_d%0d_busy", tag, d), busy_w[d], 1'b0);
            chk($sformatf("%s_d%0d_done", tag, d), done_w[d], 1'b0);
        end
    endtask

    // Advance to the next rising edge that carries baud_tick and return
    // 1 ns after it. On every non-tick edge along the way the line must
    // still hold `hold` and the handshake must show `rdy`.
    task automatic next_tick(input int sel, input logic hold, input logic rdy);
        logic t;
        for (int n = 0; n < 64; n++) begin
            @(posedge clk);
            t = baud_tick;
            #1;
            if (t) return;
            chk($sformatf("d%0d_hold_txd", sel), txd_w[sel], hold);
            chk($sformatf("d%0d_hold_rdy", sel), rdy_w[sel], rdy);
            chk($sformatf("d%0d_hold_busy", sel), busy_w[sel], ~rdy);
            chk($sformatf("d%0d_hold_done", sel), done_w[sel], 1'b0);
        end
        n_cmp++;
        n_err++;
        $error("FAIL d%0d_tick_timeout: observed=no_tick expected=tick", sel);
    endtask

    // Push one word. It must be accepted on the first rising edge.
    task automatic send(input int sel, input logic [7:0] d, input logic keep);
        @(negedge clk);
        tx_data  = d;
        vld[sel] = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("d%0d_accept_rdy", sel), rdy_w[sel], 1'b0);
        chk($sformatf("d%0d_accept_busy", sel), busy_w[sel], 1'b1);
        chk($sformatf("d%0d_accept_txd", sel), txd_w[sel], 1'b1);
        if (!keep) begin
            vld[sel] = 1'b0;
            tx_data  = ~d;   // must not reach the frame already latched
        end
    endtask

    // The frame is written as in time order, MSB = first bit on the line.
    // Check the first nchk bits on their tick edges. If the whole frame is
    // checked, also check the tx_done edge. At bit pulse_at, a busy-time
    // request carrying 0x3C is injected.
    task automatic check_frame(input int sel, input logic [11:0] bits, input int len,
                               input int nchk, input int pulse_at);
        logic cur;
        logic b;
        cur = 1'b1;
        for (int i = 0; i < nchk; i++) begin
            next_tick(sel, cur, 1'b0);
            b = bits[len-1-i];
            chk($sformatf("d%0d_bit%0d_txd", sel, i), txd_w[sel], b);
            chk($sformatf("d%0d_bit%0d_rdy", sel, i), rdy_w[sel], 1'b0);
            chk($sformatf("d%0d_bit%0d_done", sel, i), done_w[sel], 1'b0);
            cur = b;
            if (i == pulse_at) begin
                @(negedge clk);
                tx_data  = 8'h3C;
                vld[sel] = 1'b1;
                @(negedge clk);
                vld[sel] = 1'b0;
            end
        end
        if (nchk == len) begin
            next_tick(sel, cur, 1'b0);
            chk($sformatf("d%0d_end_done", sel), done_w[sel], 1'b1);
            chk($sformatf("d%0d_end_rdy", sel), rdy_w[sel], 1'b1);
            chk($sformatf("d%0d_end_busy", sel), busy_w[sel], 1'b0);
            chk($sformatf("d%0d_end_txd", sel), txd_w[sel], 1'b1);
        end
    endtask

    task automatic done_drops(input int sel);
        @(posedge clk);
        #1;
        chk($sformatf("d%0d_done_1clk", sel), done_w[sel], 1'b0);
    endtask

    initial begin
        // Reset with valid and baud_tick active. Reset must win.
        rst     = 1'b1;
        vld     = 4'b1111;
        tx_data = 8'hFF;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            chk_idle_all("reset");
        end
        @(negedge clk);
        rst = 1'b0;
        vld = 4'b0000;

        // Ticks while idle do nothing.
        next_tick(0, 1'b1, 1'b1);
        next_tick(0, 1'b1, 1'b1);
        chk_idle_all("idle_tick");

        // 8N1 0xA5 -> 0,1,0,1,0,0,1,0,1,1. Data changes after acceptance,
        // and a 0x3C request is pulsed during data bit 2.
        send(0, 8'hA5, 1'b0);
        check_frame(0, 12'b00_0101001011, 10, 10, 3);
        done_drops(0);
        next_tick(0, 1'b1, 1'b1);   // no queued frame from the busy pulse
        next_tick(0, 1'b1, 1'b1);

        // 8E1 0xA5 -> parity 0
        send(1, 8'hA5, 1'b0);
        check_frame(1, 12'b0_01010010101, 11, 11, -1);
        done_drops(1);

        // 8O1 0xA5 -> parity 1
        send(2, 8'hA5, 1'b0);
        check_frame(2, 12'b0_01010010111, 11, 11, -1);
        done_drops(2);

        // 8N2 0x00 -> nine low periods, two high periods, then ready
        send(3, 8'h00, 1'b0);
        check_frame(3, 12'b0_00000000011, 11, 11, -1);
        done_drops(3);

        // Reset during data bit 3 of 0x0F (frame 0,1,1,1,1,0,0,0,0,1)
        send(0, 8'h0F, 1'b0);
        check_frame(0, 12'b00_0111100001, 10, 5, -1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_txd", txd_w[0], 1'b1);
        chk("abort_rdy", rdy_w[0], 1'b1);
        chk("abort_busy", busy_w[0], 1'b0);
        chk("abort_done", done_w[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) next_tick(0, 1'b1, 1'b1);

        // A new word after the abort: 0x5A -> 0,0,1,0,1,1,0,1,0,1
        send(0, 8'h5A, 1'b0);
        check_frame(0, 12'b00_0010110101, 10, 10, -1);
        done_drops(0);

        // Back-to-back with valid held: 0x55 then 0xAA
        send(0, 8'h55, 1'b1);
        @(negedge clk);
        tx_data = 8'hAA;
        check_frame(0, 12'b00_0101010101, 10, 10, -1);
        @(posedge clk);
        #1;
        chk("b2b_accept_rdy", rdy_w[0], 1'b0);
        chk("b2b_accept_done", done_w[0], 1'b0);
        chk("b2b_accept_txd", txd_w[0], 1'b1);
        vld[0] = 1'b0;
        tx_data = 8'h00;
        check_frame(0, 12'b00_0010101011, 10, 10, -1);
        done_drops(0);
        next_tick(0, 1'b1, 1'b1);
        next_tick(0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_BITS, 8, payload width; legal values 5 to 8.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop-bit count; legal values 1 or 2.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all logic on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- baud_tick, input, 1, one-clk-wide strobe, one per bit period, from the baud divider.
- tx_data, input, DATA_BITS, byte to send.
- tx_valid, input, 1, tx_data is valid.
- tx_ready, output, 1, block can accept a byte.
- txd, output, 1, serial line; idle high.
- tx_busy, output, 1, frame in progress.
- tx_done, output, 1, one-clk pulse at frame end.

REQ-003 Design SHALL use the single clock clk, with the synchronous active-high reset rst; there SHALL be no other clock or asynchronous logic.

Function
REQ-004 Handshake: a byte SHALL be accepted on the rising edge where tx_valid=1 and tx_ready=1.
REQ-005 On acceptance, tx_data SHALL be latched into a shift register; later changes on tx_data SHALL NOT affect the frame.
REQ-006 tx_ready SHALL be 1 only in state IDLE; tx_busy SHALL equal the inverse of tx_ready.
REQ-007 FSM states SHALL be IDLE, WAIT, START, DATA, PAR, STOP.
REQ-008 IDLE→WAIT on acceptance; txd stays 1.
REQ-009 WAIT→START on the first baud_tick; txd←0 at that edge. Frame bits SHALL align to baud_tick, never to the acceptance cycle.
REQ-010 START→DATA on baud_tick; txd←bit0 (LSB first).
REQ-011 Each later baud_tick in DATA SHALL shift out the next bit. A bit counter SHALL count 0..DATA_BITS-1.
REQ-012 After the last data bit period, on baud_tick:
- if PARITY≠0, go to PAR and drive txd←parity;
- otherwise go to STOP and drive txd←1.
REQ-013 Parity SHALL be the XOR of the latched DATA_BITS bits; it SHALL be inverted for odd mode.
REQ-014 PAR→STOP on baud_tick; txd←1.
REQ-015 STOP SHALL last STOP_BITS baud periods. On the baud_tick that ends the final stop period, the FSM SHALL go to IDLE and tx_done SHALL pulse high for exactly one clk.
REQ-016 A baud_tick while in IDLE SHALL have no effect.
REQ-017 tx_valid while tx_ready=0 SHALL be ignored, with no queuing.
REQ-018 Back-to-back frames: if tx_valid is held high, the next byte SHALL be accepted on the first cycle tx_ready=1. No extra idle bit is required beyond the stop bits plus the WAIT alignment.
REQ-019 txd, tx_done and the FSM state SHALL be registered outputs with no combinational path from the inputs. tx_ready and tx_busy SHALL be decoded from registered state only.
REQ-020 Each bit SHALL occupy exactly one baud_tick interval on txd.

Reset
REQ-021 While rst=1, the following SHALL hold at every clk edge:
- state = IDLE;
- txd = 1, tx_done = 0, tx_ready = 1, tx_busy = 0;
- bit and stop counters = 0;
- shift register = 0.
REQ-022 rst SHALL take priority over baud_tick and tx_valid in the same cycle.
REQ-023 rst asserted mid-frame SHALL abort the frame: txd = 1 on the next edge, the byte is discarded, and no tx_done pulse is produced.

Verification
REQ-024 8N1 frame: baud_tick every 20 clk, accept 0xA5 → txd sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level held 20 clk; tx_done pulses once, concurrent with the return to IDLE.
REQ-025 Parity: PARITY=2 sends 0xA5 with parity bit 0; PARITY=1 sends it with parity bit 1; the frame is 11 bit periods.
REQ-026 Two stop bits: STOP_BITS=2, accept 0x00 → txd low for 9 periods, then high for 2 periods before tx_ready returns to 1.
REQ-027 Busy rejection and stable data:
- pulse tx_valid with 0x3C mid-frame → ignored, and the current frame is unchanged;
- changing tx_data after acceptance → the transmitted byte equals the value latched at acceptance.
REQ-028 Reset mid-frame: assert rst during data bit 3 → txd = 1, tx_ready = 1 next edge, no tx_done; a new byte accepted after reset transmits correctly.
REQ-029 Back-to-back: tx_valid held high with 0x55 then 0xAA → both frames sent in order, with no byte lost or repeated.
